gc_response_rx: RTL and testbench
=================================

# gc_response_rx

Single-wire GameCube controller response receiver running on the 1 µs `usClock`. Once armed by the host transmit side after a command (probe or poll), it decodes the controller's reply from the shared data line, bit by bit. It checks the frame length and the stop bit, then presents the reply as a raw right-aligned word plus a decoded button/axis report. It only listens: it never drives the line.

## Interface
- `SAMPLE_DLY`, default 2: number of cycles after the detected falling edge at which the bit value is sampled.
- `FIRST_TIMEOUT`, default 200: cycles allowed from `Start` to the first falling edge.
- `BIT_TIMEOUT`, default 8: cycles allowed between bits, and the maximum low time of a bit.
- `usClock`, in, 1: 1 MHz system clock.
- `Reset`, in, 1: synchronous, active-high reset. Clock is `usClock`.
- `DataIn`, in, 1: raw line value, asynchronous.
- `Start`, in, 1: one-cycle pulse that arms reception.
- `ExpBits`, in, 7: expected number of data bits, latched on `Start`. 0 or any value >64 is treated as 64.
- `Busy`, out, 1: high from the cycle after `Start` until done or error.
- `DataValid`, out, 1: one-cycle pulse when a frame completes.
- `Data`, out, 64: received bits, right-aligned, MSB-first.
- `Report`, out, 64 (`gc_report_t`): decoded view of `Data`.
- `BitCount`, out, 7: number of data bits received in the current or last frame.
- `Error`, out, 1: sticky until the next `Start`.
- `ErrCode`, out, 2: 0 none, 1 no response, 2 line stuck low, 3 short frame or missing stop bit.

## Operation
- **Synchronizer:** `DataIn` passes through a 2-flop synchronizer to give `s`. `fall` = `s_prev & ~s`.
- **IDLE:** waits for `Start`.
- **On `Start` (in any state):**
  - latch `ExpBits`;
  - clear `Data`, `BitCount`, `Error`, `ErrCode`, the timeout counter and the phase counter;
  - go to WAIT_FALL with the first-bit flag set.
  - `Start` while `Busy` aborts the current frame and restarts. No `DataValid` is issued for the aborted frame.
- **WAIT_FALL:**
  - the timeout counter increments every cycle;
  - on `fall`: go to MEASURE with phase=0;
  - if `BitCount==ExpBits`, `fall` is the stop bit: go to DONE instead;
  - timeout is reached at `FIRST_TIMEOUT` while the first-bit flag is set, giving ErrCode 1;
  - timeout is reached at `BIT_TIMEOUT` otherwise, giving ErrCode 3.
- **MEASURE:**
  - phase increments every cycle;
  - at phase==`SAMPLE_DLY`: shift the bit in with `Data <= {Data[62:0], s}`, increment `BitCount`, clear the first-bit flag, go to WAIT_RISE.
  - A `1` is 1 µs low then 3 µs high, so `s` is high at the sample. A `0` is 3 µs low then 1 µs high, so `s` is low.
- **WAIT_RISE:**
  - on `s==1`: clear the timeout counter and go to WAIT_FALL;
  - if the line stays low `BIT_TIMEOUT` cycles after entering this state: ErrCode 2.
- **DONE:** one cycle. `DataValid`=1, then IDLE.
- **ERR:** one cycle. Sets `Error` and `ErrCode`, then IDLE.
- **Output holding:**
  - `Data`, `Report` and `BitCount` hold until the next `Start`.
  - After an error, `Data` holds the partial bits received.
- **`Report` decode:**
  - valid only when `ExpBits`=64;
  - combinational function of `Data`;
  - poll layout from MSB: byte7 = {0,0,0,Start,Y,X,B,A}; byte6 = {1,L,R,Z,Up,Down,Right,Left}; then JoyX, JoyY, CX, CY, LAnalog, RAnalog.

## Timing
- **Reset values:** `Busy`=0, `DataValid`=0, `Data`=0, `BitCount`=0, `Error`=0, `ErrCode`=0, state IDLE.
- **Reset mid-frame:** returns everything to the reset values on the next edge.
- **Input latency:** 2 cycles of synchronizer latency plus 1 cycle of edge detect. This is a constant offset and does not affect the sampling decision.
- **Sampling margin:** bits are 4 cycles nominal. The sample point sits 2 cycles after `fall`, which gives ±1 cycle margin.
- **`DataValid` timing:** `DataValid` rises in the cycle after the stop-bit `fall`. `Busy` falls in that same cycle.
- **Start with `fall`:** `Start` and `fall` in the same cycle: `Start` wins, and that edge is ignored.
- **Bit count limit:** `BitCount` never exceeds 64. A falling edge with `BitCount==ExpBits` is always treated as the stop bit.

## Structure
- **Package `gc_pkg`:**
  - `CMD_PROBE`=8'h00, `CMD_POLL`=8'h40;
  - `PROBE_RESP_BITS`=24, `POLL_RESP_BITS`=64;
  - the `rx_state_t` enum;
  - the `gc_report_t` packed struct;
  - the `unpack_report()` function.
  - The transmitter shares the command constants.
- **Sub-module `gc_line_sync`:** 2-flop synchronizer plus falling-edge detector, outputs `s` and `fall`. It is reused by any future line-level block.

## Test plan
- **Probe reply:** `Start` with `ExpBits`=24, drive 24'h090003 plus a stop bit at 4 µs/bit. Expect:
  - `DataValid` pulse one cycle after the stop edge;
  - `Data`=64'h090003;
  - `BitCount`=24;
  - `Error`=0.
- **Poll reply:** `ExpBits`=64, drive 64'h0080_8080_8080_1F1F. Expect:
  - `Data` equal to the driven word;
  - `Report.JoyX`=8'h80;
  - `Report.LAnalog`=8'h1F;
  - all buttons 0 except the byte6 bit7 constant.
- **No response:** `Start`, line held high. Expect `Error`=1 and `ErrCode`=1 exactly 200 cycles after the first WAIT_FALL cycle, with `Busy`=0 afterwards.
- **Stuck low:** 10 good bits, then the line held low. Expect `ErrCode`=2, `BitCount`=11, `Data[10:0]` equal to the sent bits.
- **Short frame:** `ExpBits`=64, send 16 bits then idle high. Expect `ErrCode`=3, `BitCount`=16, and no `DataValid`.
- **Restart and reset:**
  - re-assert `Start` at bit 30 of a poll, then send a full 24-bit probe reply: expect only the probe's `DataValid`, with correct data;
  - assert `Reset` mid-frame: expect all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/gc_pkg.sv
// Shared GameCube controller link definitions: command bytes, reply sizes,
// receiver state encoding and the decoded poll report layout.
package gc_pkg;

  localparam logic [7:0] CMD_PROBE       = 8'h00;
  localparam logic [7:0] CMD_POLL        = 8'h40;
  localparam int         PROBE_RESP_BITS = 24;
  localparam int         POLL_RESP_BITS  = 64;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_WAIT_FALL = 3'd1,
    RX_MEASURE   = 3'd2,
    RX_WAIT_RISE = 3'd3,
    RX_DONE      = 3'd4,
    RX_ERR       = 3'd5
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_NO_RESP   = 2'd1,
    ERR_STUCK_LOW = 2'd2,
    ERR_SHORT     = 2'd3
  } rx_err_t;

  // Poll reply, MSB first: two button bytes then six analog bytes.
  typedef struct packed {
    logic [2:0] pad;
    logic       start;
    logic       y;
    logic       x;
    logic       b;
    logic       a;
    logic       one;
    logic       l;
    logic       r;
    logic       z;
    logic       up;
    logic       down;
    logic       right;
    logic       left;
    logic [7:0] joy_x;
    logic [7:0] joy_y;
    logic [7:0] c_x;
    logic [7:0] c_y;
    logic [7:0] l_analog;
    logic [7:0] r_analog;
  } gc_report_t;

  function automatic gc_report_t unpack_report(input logic [63:0] data);
    return gc_report_t'(data);
  endfunction

endpackage

// File: rtl/gc_line_sync.sv
// Two-flop synchronizer for the shared controller line plus a falling-edge
// detector on the synchronized value.
module gc_line_sync (
  input  logic usClock,
  input  logic Reset,
  input  logic line_i,
  output logic s_o,
  output logic fall_o
);

  logic meta_q;
  logic s_q;
  logic s_prev_q;

  // The idle line is pulled high, so reset to 1 to avoid a phantom edge.
  always_ff @(posedge usClock) begin
    if (Reset) begin
      meta_q   <= 1'b1;
      s_q      <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      meta_q   <= line_i;
      s_q      <= meta_q;
      s_prev_q <= s_q;
    end
  end

  assign s_o    = s_q;
  assign fall_o = s_prev_q & ~s_q;

endmodule

// File: rtl/gc_response_rx.sv
// Receiver for the controller's reply on the single-wire link: times each bit
// from its falling edge, checks length and stop bit, and exposes the frame.
module gc_response_rx
  import gc_pkg::*;
#(
  parameter int SAMPLE_DLY    = 2,
  parameter int FIRST_TIMEOUT = 200,
  parameter int BIT_TIMEOUT   = 8
) (
  input  logic        usClock,
  input  logic        Reset,
  input  logic        DataIn,
  input  logic        Start,
  input  logic [6:0]  ExpBits,
  output logic        Busy,
  output logic        DataValid,
  output logic [63:0] Data,
  output gc_report_t  Report,
  output logic [6:0]  BitCount,
  output logic        Error,
  output logic [1:0]  ErrCode
);

  localparam int TMO_MAX = (FIRST_TIMEOUT > BIT_TIMEOUT) ? FIRST_TIMEOUT : BIT_TIMEOUT;
  localparam int TMO_W   = $clog2(TMO_MAX + 1);
  localparam int PH_W    = $clog2(SAMPLE_DLY + 1);

  localparam logic [TMO_W-1:0] FIRST_LAST = TMO_W'(FIRST_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] BIT_LAST   = TMO_W'(BIT_TIMEOUT - 1);
  // The fall cycle itself is phase 0 of the bit; MEASURE starts one cycle later.
  localparam logic [PH_W-1:0]  SAMPLE_AT  = PH_W'(SAMPLE_DLY - 1);

  logic s;
  logic fall;

  gc_line_sync u_sync (
    .usClock (usClock),
    .Reset   (Reset),
    .line_i  (DataIn),
    .s_o     (s),
    .fall_o  (fall)
  );

  rx_state_t        state_q,   state_d;
  logic [6:0]       exp_q,     exp_d;
  logic [63:0]      data_q,    data_d;
  logic [6:0]       bitcnt_q,  bitcnt_d;
  logic             first_q,   first_d;
  logic             err_q,     err_d;
  logic [1:0]       errcode_q, errcode_d;
  logic [TMO_W-1:0] tmo_q,     tmo_d;
  logic [PH_W-1:0]  phase_q,   phase_d;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    data_d    = data_q;
    bitcnt_d  = bitcnt_q;
    first_d   = first_q;
    err_d     = err_q;
    errcode_d = errcode_q;
    tmo_d     = tmo_q;
    phase_d   = phase_q;

    if (Start) begin
      exp_d     = (ExpBits == 7'd0 || ExpBits > 7'd64) ? 7'd64 : ExpBits;
      data_d    = '0;
      bitcnt_d  = '0;
      err_d     = 1'b0;
      errcode_d = ERR_NONE;
      tmo_d     = '0;
      phase_d   = '0;
      first_d   = 1'b1;
      state_d   = RX_WAIT_FALL;
    end else begin
      unique case (state_q)
        RX_IDLE: ;
        RX_WAIT_FALL: begin
          tmo_d = tmo_q + TMO_W'(1);
          if (fall) begin
            tmo_d = '0;
            if (bitcnt_q == exp_q) begin
              state_d = RX_DONE;
            end else begin
              phase_d = '0;
              state_d = RX_MEASURE;
            end
          end else if (first_q && tmo_q == FIRST_LAST) begin
            err_d     = 1'b1;
            errcode_d = ERR_NO_RESP;
            state_d   = RX_ERR;
          end else if (!first_q && tmo_q == BIT_LAST) begin
            err_d     = 1'b1;
            errcode_d = ERR_SHORT;
            state_d   = RX_ERR;
          end
        end
        RX_MEASURE: begin
          phase_d = phase_q + PH_W'(1);
          if (phase_q == SAMPLE_AT) begin
            data_d   = {data_q[62:0], s};
            bitcnt_d = bitcnt_q + 7'd1;
            first_d  = 1'b0;
            tmo_d    = '0;
            state_d  = RX_WAIT_RISE;
          end
        end
        RX_WAIT_RISE: begin
          tmo_d = tmo_q + TMO_W'(1);
          if (s) begin
            tmo_d   = '0;
            state_d = RX_WAIT_FALL;
          end else if (tmo_q == BIT_LAST) begin
            err_d     = 1'b1;
            errcode_d = ERR_STUCK_LOW;
            state_d   = RX_ERR;
          end
        end
        RX_DONE, RX_ERR: state_d = RX_IDLE;
        default:         state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge usClock) begin
    if (Reset) begin
      state_q   <= RX_IDLE;
      exp_q     <= 7'd64;
      data_q    <= '0;
      bitcnt_q  <= '0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
      errcode_q <= ERR_NONE;
      tmo_q     <= '0;
      phase_q   <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      data_q    <= data_d;
      bitcnt_q  <= bitcnt_d;
      first_q   <= first_d;
      err_q     <= err_d;
      errcode_q <= errcode_d;
      tmo_q     <= tmo_d;
      phase_q   <= phase_d;
    end
  end

  assign Busy      = (state_q == RX_WAIT_FALL) || (state_q == RX_MEASURE) ||
                     (state_q == RX_WAIT_RISE);
  assign DataValid = (state_q == RX_DONE);
  assign Data      = data_q;
  assign Report    = unpack_report(data_q);
  assign BitCount  = bitcnt_q;
  assign Error     = err_q;
  assign ErrCode   = errcode_q;

endmodule

// File: tb/tb_gc_response_rx.sv
// Directed bench for gc_response_rx: stimulus queues the expected frame
// outcome, a negedge monitor compares it when DataValid or Error appears.
`timescale 1ns/1ps
module tb_gc_response_rx;
  import gc_pkg::*;

  logic        usClock = 1'b0;
  logic        Reset;
  logic        DataIn;
  logic        Start;
  logic [6:0]  ExpBits;
  logic        Busy;
  logic        DataValid;
  logic [63:0] Data;
  gc_report_t  Report;
  logic [6:0]  BitCount;
  logic        Error;
  logic [1:0]  ErrCode;

  gc_response_rx dut (
    .usClock   (usClock),
    .Reset     (Reset),
    .DataIn    (DataIn),
    .Start     (Start),
    .ExpBits   (ExpBits),
    .Busy      (Busy),
    .DataValid (DataValid),
    .Data      (Data),
    .Report    (Report),
    .BitCount  (BitCount),
    .Error     (Error),
    .ErrCode   (ErrCode)
  );

  always #5 usClock = ~usClock;

  typedef struct {
    bit          is_err;
    logic [63:0] data;
    int          bits;
    logic [1:0]  code;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  logic err_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic push(input bit is_err, input logic [63:0] data, input int bits,
                      input logic [1:0] code);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    e.bits   = bits;
    e.code   = code;
    q.push_back(e);
  endtask

  // Monitor: every frame outcome must match the head of the scoreboard.
  always @(negedge usClock) begin
    if (mon_en && (DataValid || (Error && !err_prev))) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {62'd0, DataValid, Error}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("evt_is_err", {63'd0, Error}, {63'd0, e.is_err});
        chk("evt_valid", {63'd0, DataValid}, {63'd0, !e.is_err});
        chk("evt_busy", {63'd0, Busy}, 64'd0);
        chk("evt_data", Data, e.data);
        chk("evt_bitcount", {57'd0, BitCount}, 64'(e.bits));
        chk("evt_errcode", {62'd0, ErrCode}, {62'd0, e.code});
        $display("frame: err=%0b code=%0d bits=%0d data=%h", Error, ErrCode, BitCount, Data);
      end
    end
    err_prev <= Error;
  end

  task automatic start_rx(input logic [6:0] n);
    ExpBits = n;
    Start   = 1'b1;
    @(negedge usClock);
    Start   = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    DataIn = 1'b0;
    repeat (b ? 1 : 3) @(negedge usClock);
    DataIn = 1'b1;
    repeat (b ? 3 : 1) @(negedge usClock);
  endtask

  task automatic send_word(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge usClock);
    repeat (4) @(negedge usClock);
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    Reset   = 1'b1;
    DataIn  = 1'b1;
    Start   = 1'b0;
    ExpBits = 7'd0;
    repeat (3) @(negedge usClock);
    Reset = 1'b0;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_valid", {63'd0, DataValid}, 64'd0);
    chk("rst_data", Data, 64'd0);
    chk("rst_bitcount", {57'd0, BitCount}, 64'd0);
    chk("rst_error", {63'd0, Error}, 64'd0);
    chk("rst_errcode", {62'd0, ErrCode}, 64'd0);
    mon_en = 1'b1;

    // Probe reply
    start_rx(7'd24);
    push(1'b0, 64'h090003, 24, 2'd0);
    send_word(64'h090003, 24);
    send_bit(1'b1);
    drain("probe_drain");

    // Poll reply
    start_rx(7'd64);
    push(1'b0, 64'h0080_8080_8080_1F1F, 64, 2'd0);
    send_word(64'h0080_8080_8080_1F1F, 64);
    send_bit(1'b1);
    drain("poll_drain");
    chk("poll_joy_x", {56'd0, Report.joy_x}, 64'h80);
    chk("poll_l_analog", {56'd0, Report.l_analog}, 64'h1F);
    chk("poll_buttons", {52'd0, Report.start, Report.y, Report.x, Report.b, Report.a,
        Report.l, Report.r, Report.z, Report.up, Report.down, Report.right, Report.left}, 64'd0);
    chk("poll_one", {63'd0, Report.one}, 64'd1);

    // ExpBits of 0 means a full 64-bit frame
    start_rx(7'd0);
    push(1'b0, 64'h1F7F_0123_4567_89AB, 64, 2'd0);
    send_word(64'h1F7F_0123_4567_89AB, 64);
    send_bit(1'b1);
    drain("exp0_drain");
    chk("exp0_start_btn", {63'd0, Report.start}, 64'd1);
    chk("exp0_joy_x", {56'd0, Report.joy_x}, 64'h01);

    // No response: error lands 200 cycles after the first WAIT_FALL cycle
    start_rx(7'd24);
    push(1'b1, 64'd0, 0, 2'd1);
    repeat (199) @(negedge usClock);
    chk("noresp_early", {63'd0, Error}, 64'd0);
    @(negedge usClock);
    chk("noresp_error", {63'd0, Error}, 64'd1);
    chk("noresp_code", {62'd0, ErrCode}, 64'd1);
    chk("noresp_busy", {63'd0, Busy}, 64'd0);
    drain("noresp_drain");

    // Stuck low after 10 good bits
    start_rx(7'd24);
    push(1'b1, 64'h59C, 11, 2'd2);
    send_word(64'h2CE, 10);
    DataIn = 1'b0;
    repeat (20) @(negedge usClock);
    DataIn = 1'b1;
    drain("stuck_drain");

    // Short frame
    start_rx(7'd64);
    push(1'b1, 64'hA5C3, 16, 2'd3);
    send_word(64'hA5C3, 16);
    repeat (20) @(negedge usClock);
    drain("short_drain");

    // Restart mid-poll, then a full probe reply
    start_rx(7'd64);
    send_word(64'h0080_8080_8080_1F1F >> 34, 30);
    start_rx(7'd24);
    chk("restart_bitcount", {57'd0, BitCount}, 64'd0);
    chk("restart_data", Data, 64'd0);
    chk("restart_busy", {63'd0, Busy}, 64'd1);
    push(1'b0, 64'h090003, 24, 2'd0);
    send_word(64'h090003, 24);
    send_bit(1'b1);
    drain("restart_drain");

    // Reset mid-frame
    start_rx(7'd64);
    send_word(64'hABC, 12);
    DataIn = 1'b0;
    Reset  = 1'b1;
    @(negedge usClock);
    chk("midrst_busy", {63'd0, Busy}, 64'd0);
    chk("midrst_valid", {63'd0, DataValid}, 64'd0);
    chk("midrst_data", Data, 64'd0);
    chk("midrst_bitcount", {57'd0, BitCount}, 64'd0);
    chk("midrst_error", {63'd0, Error}, 64'd0);
    chk("midrst_errcode", {62'd0, ErrCode}, 64'd0);
    DataIn = 1'b1;
    Reset  = 1'b0;
    repeat (20) @(negedge usClock);
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
